// File: rtl/rtu_sync_vc_if.sv
// Flit bus around the routing unit: the upstream side (in_*) and the
// downstream side (out_*, out_port) of a single valid/ready register stage.
//   slave  : the routing unit (takes in_*, produces in_ready and out_*)
//   master : the environment (VC buffer upstream, allocator downstream)
// Parameters VCN and DW must match the attached rtu_sync_vc instance.
`timescale 1ns/1ps
interface rtu_sync_vc_if #(
  parameter int VCN = 2,
  parameter int DW  = 32
) ();
  localparam int VCW = (VCN > 1) ? $clog2(VCN) : 1;

  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_ftype;
  logic [VCW-1:0] in_vc;
  logic [DW-1:0]  in_data;

  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_ftype;
  logic [VCW-1:0] out_vc;
  logic [DW-1:0]  out_data;
  logic [4:0]     out_port;

  modport slave (
    input  in_valid, in_ftype, in_vc, in_data, out_ready,
    output in_ready, out_valid, out_ftype, out_vc, out_data, out_port
  );

  modport master (
    output in_valid, in_ftype, in_vc, in_data, out_ready,
    input  in_ready, out_valid, out_ftype, out_vc, out_data, out_port
  );
endinterface

// File: rtl/rtu_sync_vc.sv
// Routing computation unit for one router input port.
// Head flits carry a destination (x,y); the unit computes a one-hot output
// port request {L,E,N,W,S}, locks it per virtual channel until the tail, and
// forwards every flit through one valid/ready register stage.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   addr_x, addr_y    this router's coordinates
//   bus (slave)       in_valid/in_ready/in_ftype/in_vc/in_data upstream,
//                     out_valid/out_ready/out_ftype/out_vc/out_data/out_port downstream
//   err_proto         sticky protocol violation flag
//   err_uturn         sticky flag: a route pointed back to input direction DIR
`timescale 1ns/1ps
module rtu_sync_vc #(
  parameter int VCN  = 2,
  parameter int DIR  = 0,
  parameter int AW   = 8,
  parameter int DW   = 32,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_x,
  input  logic [AW-1:0] addr_y,
  rtu_sync_vc_if.slave  bus,
  output logic          err_proto,
  output logic          err_uturn
);
  localparam int VCW = (VCN > 1) ? $clog2(VCN) : 1;

  localparam logic [4:0] P_S = 5'b00001;
  localparam logic [4:0] P_W = 5'b00010;
  localparam logic [4:0] P_N = 5'b00100;
  localparam logic [4:0] P_E = 5'b01000;
  localparam logic [4:0] P_L = 5'b10000;

  typedef enum logic [1:0] {
    FT_BODY     = 2'd0,
    FT_HEAD     = 2'd1,
    FT_TAIL     = 2'd2,
    FT_HEADTAIL = 2'd3
  } ftype_t;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_t;

  vc_state_t      vc_state [VCN];
  logic [4:0]     lock     [VCN];

  logic           out_valid_q;
  logic [1:0]     out_ftype_q;
  logic [VCW-1:0] out_vc_q;
  logic [DW-1:0]  out_data_q;
  logic [4:0]     out_port_q;

  logic           in_ready;
  logic           accept;
  logic           vc_ok;
  logic [VCW-1:0] vc_idx;
  logic           is_head;
  vc_state_t      cur_state;
  logic [4:0]     cur_lock;
  logic [AW-1:0]  dest_x;
  logic [AW-1:0]  dest_y;
  logic [4:0]     route;
  logic [4:0]     nxt_port;
  logic           set_proto;
  logic           set_uturn;

  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ftype = out_ftype_q;
  assign bus.out_vc    = out_vc_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_port  = out_port_q;

  assign dest_x  = bus.in_data[AW-1:0];
  assign dest_y  = bus.in_data[2*AW-1:AW];
  assign is_head = (bus.in_ftype == FT_HEAD) || (bus.in_ftype == FT_HEADTAIL);

  // An out-of-range VC index is steered to VC 0 for the state lookup only;
  // vc_ok keeps it from touching any FSM.
  assign vc_ok     = (int'(bus.in_vc) < VCN);
  assign vc_idx    = vc_ok ? bus.in_vc : '0;
  assign cur_state = vc_state[vc_idx];
  assign cur_lock  = lock[vc_idx];

  // Dimension-ordered route: MODE 0 settles X before Y, MODE 1 the reverse.
  always_comb begin
    route = P_L;
    if (MODE == 0) begin
      if (dest_x != addr_x)      route = (dest_x > addr_x) ? P_E : P_W;
      else if (dest_y != addr_y) route = (dest_y > addr_y) ? P_N : P_S;
    end else begin
      if (dest_y != addr_y)      route = (dest_y > addr_y) ? P_N : P_S;
      else if (dest_x != addr_x) route = (dest_x > addr_x) ? P_E : P_W;
    end
  end

  // Port selection and error detection for the flit currently offered.
  // A head on an already active VC is re-routed as if the VC were idle.
  always_comb begin
    nxt_port  = 5'b00000;
    set_proto = 1'b0;
    set_uturn = 1'b0;
    if (!vc_ok) begin
      set_proto = 1'b1;
    end else if (is_head) begin
      nxt_port = route;
      if (cur_state == VC_ACTIVE) set_proto = 1'b1;
      if ((DIR < 4) && route[DIR]) set_uturn = 1'b1;
    end else if (cur_state == VC_ACTIVE) begin
      nxt_port = cur_lock;
    end else begin
      set_proto = 1'b1;
    end
  end

  // Output register, per-VC route locks and FSMs all update on the same
  // edge, so a flit accepted in the next cycle already sees the new lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ftype_q <= '0;
      out_vc_q    <= '0;
      out_data_q  <= '0;
      out_port_q  <= '0;
      err_proto   <= 1'b0;
      err_uturn   <= 1'b0;
      for (int i = 0; i < VCN; i++) begin
        vc_state[i] <= VC_IDLE;
        lock[i]     <= '0;
      end
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_ftype_q <= bus.in_ftype;
      out_vc_q    <= bus.in_vc;
      out_data_q  <= bus.in_data;
      out_port_q  <= nxt_port;
      if (set_proto) err_proto <= 1'b1;
      if (set_uturn) err_uturn <= 1'b1;
      if (vc_ok) begin
        if (bus.in_ftype == FT_HEAD) begin
          lock[vc_idx]     <= route;
          vc_state[vc_idx] <= VC_ACTIVE;
        end else if (bus.in_ftype == FT_HEADTAIL) begin
          vc_state[vc_idx] <= VC_IDLE;
        end else if ((bus.in_ftype == FT_TAIL) && (cur_state == VC_ACTIVE)) begin
          vc_state[vc_idx] <= VC_IDLE;
        end
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule
